nnrv_mem_arb: RTL and testbench

NNRV_MEM_ARB -- requirements
Module: nnrv_mem_arb

---
 rtl/nnrv_mem_arb.sv | 91 +++++++++
 tb/tb_nnrv_mem_arb.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/nnrv_mem_arb.sv
// Two-master arbiter (instruction fetch, load/store) onto one single-port
// 1-cycle-latency RAM. LSU wins by default; a starved fetch is forced ahead.
module nnrv_mem_arb #(
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned AW       = 30
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_if_req,
  input  logic [31:0]   i_if_addr,
  output logic          o_if_gnt,
  output logic          o_if_rvalid,
  output logic [31:0]   o_if_rdata,
  input  logic          i_ls_req,
  input  logic          i_ls_we,
  input  logic [3:0]    i_ls_be,
  input  logic [31:0]   i_ls_addr,
  input  logic [31:0]   i_ls_wdata,
  output logic          o_ls_gnt,
  output logic          o_ls_rvalid,
  output logic [31:0]   o_ls_rdata,
  output logic          o_ram_en,
  output logic [3:0]    o_ram_we,
  output logic [AW-1:0] o_ram_addr,
  output logic [31:0]   o_ram_wdata,
  input  logic [31:0]   i_ram_rdata,
  output logic [3:0]    o_wait_cnt
);

  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_LS} owner_t;

  owner_t      owner_q, owner_d;
  logic [3:0]  wait_q, wait_d;
  logic [31:0] if_hold_q, ls_hold_q;
  logic        if_force;

  assign if_force = (wait_q >= 4'(MAX_WAIT));

  // NOTE: every signal gets a default before any branch, so no latch is inferred.
  always_comb begin
    o_if_gnt    = 1'b0;
    o_ls_gnt    = 1'b0;
    o_ram_en    = 1'b0;
    o_ram_we    = 4'b0000;
    o_ram_addr  = '0;
    o_ram_wdata = '0;
    owner_d     = OWN_NONE;
    wait_d      = 4'd0;
    // Grants are gated by reset so nothing leaks out while i_rst is high.
    if (!i_rst) begin
      o_ls_gnt = i_ls_req && !(i_if_req && if_force);
      o_if_gnt = i_if_req && !o_ls_gnt;
      if (o_ls_gnt) begin
        o_ram_en    = 1'b1;
        o_ram_addr  = i_ls_addr[AW+1:2];
        o_ram_we    = i_ls_we ? i_ls_be : 4'b0000;
        o_ram_wdata = i_ls_wdata;
        owner_d     = i_ls_we ? OWN_NONE : OWN_LS;
      end else if (o_if_gnt) begin
        o_ram_en   = 1'b1;
        o_ram_addr = i_if_addr[AW+1:2];
        owner_d    = OWN_IF;
      end
      if (i_if_req && !o_if_gnt)
        wait_d = (wait_q == 4'd15) ? wait_q : wait_q + 4'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      owner_q   <= OWN_NONE;
      wait_q    <= 4'd0;
      if_hold_q <= '0;
      ls_hold_q <= '0;
    end else begin
      owner_q <= owner_d;
      wait_q  <= wait_d;
      if (o_if_rvalid) if_hold_q <= i_ram_rdata;
      if (o_ls_rvalid) ls_hold_q <= i_ram_rdata;
    end
  end

  // Read data is passed straight through on the rvalid cycle, then held.
  assign o_if_rvalid = (owner_q == OWN_IF);
  assign o_ls_rvalid = (owner_q == OWN_LS);
  assign o_if_rdata  = o_if_rvalid ? i_ram_rdata : if_hold_q;
  assign o_ls_rdata  = o_ls_rvalid ? i_ram_rdata : ls_hold_q;
  assign o_wait_cnt  = wait_q;

endmodule

// File: tb/tb_nnrv_mem_arb.sv
// Scoreboard bench for nnrv_mem_arb: a small arbitration model predicts grants,
// read results are queued on grant and popped when rvalid appears.
module tb_nnrv_mem_arb;

  localparam int unsigned MAX_WAIT = 4;
  localparam int unsigned AW       = 30;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_if_req = 1'b0;
  logic [31:0]   i_if_addr = '0;
  logic          o_if_gnt, o_if_rvalid;
  logic [31:0]   o_if_rdata;
  logic          i_ls_req = 1'b0, i_ls_we = 1'b0;
  logic [3:0]    i_ls_be = '0;
  logic [31:0]   i_ls_addr = '0, i_ls_wdata = '0;
  logic          o_ls_gnt, o_ls_rvalid;
  logic [31:0]   o_ls_rdata;
  logic          o_ram_en;
  logic [3:0]    o_ram_we;
  logic [AW-1:0] o_ram_addr;
  logic [31:0]   o_ram_wdata;
  logic [31:0]   i_ram_rdata = '0;
  logic [3:0]    o_wait_cnt;

  nnrv_mem_arb #(.MAX_WAIT(MAX_WAIT), .AW(AW)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_gnt(o_if_gnt),
    .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
    .i_ls_req(i_ls_req), .i_ls_we(i_ls_we), .i_ls_be(i_ls_be),
    .i_ls_addr(i_ls_addr), .i_ls_wdata(i_ls_wdata), .o_ls_gnt(o_ls_gnt),
    .o_ls_rvalid(o_ls_rvalid), .o_ls_rdata(o_ls_rdata),
    .o_ram_en(o_ram_en), .o_ram_we(o_ram_we), .o_ram_addr(o_ram_addr),
    .o_ram_wdata(o_ram_wdata), .i_ram_rdata(i_ram_rdata), .o_wait_cnt(o_wait_cnt)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
  endtask

  // RAM content is a fixed function of the word address.
  function automatic logic [31:0] ram_word(input logic [29:0] a);
    return ({2'b00, a} * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // Synchronous RAM model; non-read cycles return garbage so holds are tested.
  always @(posedge i_clk) begin
    if (o_ram_en && o_ram_we == 4'b0000) i_ram_rdata <= ram_word(o_ram_addr);
    else                                 i_ram_rdata <= $urandom;
  end

  logic [31:0] if_q[$];
  logic [31:0] ls_q[$];
  logic [31:0] last_if = '0, last_ls = '0;
  logic [3:0]  ref_wait = '0;

  // Queued entries were pushed on the previous rising edge, so a non-empty
  // queue means rvalid is due on this cycle.
  always @(negedge i_clk) begin
    if (!i_rst) begin
      check("if_rvalid", o_if_rvalid, 32'(if_q.size() != 0));
      check("ls_rvalid", o_ls_rvalid, 32'(ls_q.size() != 0));
      if (if_q.size() != 0) last_if = if_q.pop_front();
      if (ls_q.size() != 0) last_ls = ls_q.pop_front();
      check("if_rdata", o_if_rdata, last_if);
      check("ls_rdata", o_ls_rdata, last_ls);
    end
  end

  // One clock of stimulus: drive, predict, compare at negedge, queue reads.
  task automatic step(input logic ifr, input logic [31:0] ifa,
                      input logic lsr, input logic we, input logic [3:0] be,
                      input logic [31:0] lsa, input logic [31:0] wd);
    logic e_if, e_ls;
    logic [31:0] e_addr;
    i_if_req = ifr; i_if_addr = ifa;
    i_ls_req = lsr; i_ls_we = we; i_ls_be = be; i_ls_addr = lsa; i_ls_wdata = wd;
    e_if = ifr && (!lsr || ref_wait >= 4'(MAX_WAIT));
    e_ls = lsr && !e_if;
    e_addr = e_ls ? {2'b00, lsa[31:2]} : e_if ? {2'b00, ifa[31:2]} : 32'h0;
    @(negedge i_clk);
    check("if_gnt", o_if_gnt, e_if);
    check("ls_gnt", o_ls_gnt, e_ls);
    check("ram_en", o_ram_en, e_if | e_ls);
    check("ram_addr", 32'(o_ram_addr), e_addr);
    check("ram_we", o_ram_we, (e_ls && we) ? be : 4'b0000);
    check("ram_wdata", o_ram_wdata, e_ls ? wd : 32'h0);
    check("wait_cnt", o_wait_cnt, ref_wait);
    @(posedge i_clk);
    if (e_if)             if_q.push_back(ram_word(ifa[31:2]));
    if (e_ls && !we)      ls_q.push_back(ram_word(lsa[31:2]));
    if (!ifr || e_if)     ref_wait = 4'd0;
    else if (ref_wait != 4'd15) ref_wait = ref_wait + 4'd1;
    #1;
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"},    {o_if_gnt, o_ls_gnt}, 0);
    check({tag, "_rvalid"}, {o_if_rvalid, o_ls_rvalid}, 0);
    check({tag, "_ram"},    {o_ram_en, o_ram_we}, 0);
    check({tag, "_addr"},   32'(o_ram_addr), 0);
    check({tag, "_wdata"},  o_ram_wdata, 0);
    check({tag, "_rdata"},  o_if_rdata | o_ls_rdata, 0);
    check({tag, "_wait"},   o_wait_cnt, 0);
  endtask

  initial begin
    // Reset with both masters requesting: everything must stay at zero.
    i_if_req = 1'b1; i_ls_req = 1'b1; i_ls_addr = 32'h40; i_if_addr = 32'h80;
    repeat (3) @(negedge i_clk);
    check_all_zero("rst");
    @(posedge i_clk); #1;
    i_rst = 1'b0;

    // Fetch alone in the first out-of-reset cycle, byte addr 0x10 -> word 0x4.
    step(1'b1, 32'h0000_0010, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    idle();

    // Both requesting: LSU four times, then starved fetch forced through.
    for (int i = 0; i < 6; i++)
      step(1'b1, 32'h100 + 32'(4 * i), 1'b1, 1'b0, 4'h0, 32'h200 + 32'(4 * i), 32'h0);
    idle();

    // Store: byte enables and data forwarded, no load response.
    step(1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h0000_0020, 32'hDEAD_BEEF);
    idle();

    // Fetch then load on consecutive cycles; fetch data must hold meanwhile.
    step(1'b1, 32'h0000_0304, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0000_0408, 32'h0);
    idle();
    idle();

    // Random traffic, biased toward contention.
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 7,
           1'($urandom), 4'($urandom), $urandom, $urandom);
    idle();

    // Reset asserted mid-cycle right after a fetch grant.
    step(1'b1, 32'h0000_0500, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    i_if_req = 1'b1; i_ls_req = 1'b1;
    #2 i_rst = 1'b1;
    if_q.delete(); ls_q.delete();
    last_if = '0; last_ls = '0; ref_wait = '0;
    #1 check_all_zero("midrst");
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    idle();
    idle();

    check("if_q_drained", if_q.size(), 0);
    check("ls_q_drained", ls_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
